// File: rtl/led_pixel_deser.sv
// Serial-to-parallel pixel loader: gathers LANES-wide beats under DEN into PIX_W-bit
// words and writes each finished word to the frame buffer through a registered strobe.
module led_pixel_deser #(
   parameter int PIX_W     = 16,
   parameter int LANES     = 1,
   parameter int ADDR_W    = 9,
   parameter int NUM_PIX   = 512,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              DCK,
   input  logic              rst,
   input  logic [LANES-1:0]  DAI,
   input  logic              DEN,
   input  logic              clr,
   output logic [ADDR_W-1:0] AB,
   output logic [PIX_W-1:0]  DB,
   output logic              WEN,
   output logic              frame_done,
   output logic              short_err,
   output logic [ADDR_W-1:0] pix_cnt
);

   localparam int BEATS  = PIX_W / LANES;
   localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIX - 1);

   logic [BCNT_W-1:0] r_bcnt;
   logic [PIX_W-1:0]  r_sh;
   logic [ADDR_W-1:0] r_ab;
   logic [PIX_W-1:0]  r_db;
   logic              r_wen;
   logic              r_done;
   logic              r_err;
   logic [ADDR_W-1:0] r_pix;

   logic [PIX_W-1:0]  w_word;
   logic [IDX_W-1:0]  w_base;
   logic              w_complete;
   logic              w_last_pix;

   assign w_complete = DEN && (r_bcnt == LAST_BEAT);
   assign w_last_pix = (r_pix == LAST_PIX);

   // Current word with this edge's beat dropped into its slot; the lowest lane bit
   // always lands on the lowest bit of the slot, whichever end the word fills from.
   always_comb begin
      w_word = r_sh;
      if (MSB_FIRST)
         w_base = IDX_W'(PIX_W - LANES - int'(r_bcnt) * LANES);
      else
         w_base = IDX_W'(int'(r_bcnt) * LANES);
      for (int i = 0; i < LANES; i++)
         w_word[w_base + IDX_W'(i)] = DAI[i];
   end

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge DCK or posedge rst) begin
      if (rst) begin
         r_bcnt <= '0;
         r_sh   <= '0;
         r_ab   <= '0;
         r_db   <= '0;
         r_wen  <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_pix  <= '0;
      end else begin
         r_wen  <= w_complete;
         r_done <= w_complete && w_last_pix;
         r_err  <= !DEN && !clr && (r_bcnt != '0);

         if (w_complete) begin
            r_ab <= r_pix;
            r_db <= w_word;
         end

         // clr beats the pixel increment but still lets a finishing word out above.
         if (clr) begin
            r_bcnt <= '0;
            r_sh   <= '0;
            r_pix  <= '0;
         end else if (DEN) begin
            if (w_complete) begin
               r_bcnt <= '0;
               r_sh   <= '0;
               r_pix  <= w_last_pix ? '0 : r_pix + 1'b1;
            end else begin
               r_bcnt <= r_bcnt + 1'b1;
               r_sh   <= w_word;
            end
         end else begin
            r_bcnt <= '0;
            r_sh   <= '0;
         end
      end
   end

   assign AB         = r_ab;
   assign DB         = r_db;
   assign WEN        = r_wen;
   assign frame_done = r_done;
   assign short_err  = r_err;
   assign pix_cnt    = r_pix;

endmodule

// File: tb/tb_led_pixel_deser.sv
// Directed bench for led_pixel_deser: a 1-lane 4-pixel frame instance plus two
// 4-lane instances (MSB-first and LSB-first) fed with identical beats.
module tb_led_pixel_deser;

   typedef struct {
      logic [15:0] data;
      logic [8:0]  ab;
      logic        fd;
      logic [8:0]  pc;
   } word_vec_t;

   typedef struct {
      logic [15:0] beats;    // beat 0 in [15:12]
      logic [15:0] exp_msb;
      logic [15:0] exp_lsb;
   } lane_vec_t;

   logic        DCK = 1'b0;
   logic        rst = 1'b0;

   logic        dai1 = 1'b0, den1 = 1'b0, clr1 = 1'b0;
   logic [8:0]  ab1, pc1;
   logic [15:0] db1;
   logic        wen1, fd1, se1;

   logic [3:0]  dai4 = 4'h0;
   logic        den4 = 1'b0;
   logic        clr4 = 1'b0;
   logic [8:0]  abm, pcm, abl, pcl;
   logic [15:0] dbm, dbl;
   logic        wenm, fdm, sem, wenl, fdl, sel;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 DCK = ~DCK;

   led_pixel_deser #(.PIX_W(16), .LANES(1), .ADDR_W(9), .NUM_PIX(4), .MSB_FIRST(1'b0)) u_dut (
      .DCK(DCK), .rst(rst), .DAI(dai1), .DEN(den1), .clr(clr1),
      .AB(ab1), .DB(db1), .WEN(wen1), .frame_done(fd1), .short_err(se1), .pix_cnt(pc1));

   led_pixel_deser #(.PIX_W(16), .LANES(4), .ADDR_W(9), .NUM_PIX(512), .MSB_FIRST(1'b1)) u_msb (
      .DCK(DCK), .rst(rst), .DAI(dai4), .DEN(den4), .clr(clr4),
      .AB(abm), .DB(dbm), .WEN(wenm), .frame_done(fdm), .short_err(sem), .pix_cnt(pcm));

   led_pixel_deser #(.PIX_W(16), .LANES(4), .ADDR_W(9), .NUM_PIX(512), .MSB_FIRST(1'b0)) u_lsb (
      .DCK(DCK), .rst(rst), .DAI(dai4), .DEN(den4), .clr(clr4),
      .AB(abl), .DB(dbl), .WEN(wenl), .frame_done(fdl), .short_err(sel), .pix_cnt(pcl));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one edge's worth of 1-lane inputs and return just after that edge.
   task automatic tick(input logic den, input logic dai, input logic c);
      den1 = den;
      dai1 = dai;
      clr1 = c;
      @(posedge DCK);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) tick(1'b1, d[i], 1'b0);
   endtask

   task automatic tick4(input logic den, input logic [3:0] beat);
      den4 = den;
      dai4 = beat;
      @(posedge DCK);
      #1;
   endtask

   word_vec_t words[5];
   lane_vec_t lanes[3];

   initial begin
      words[0] = '{16'hA5C3, 9'd0, 1'b0, 9'd1};
      words[1] = '{16'h1234, 9'd1, 1'b0, 9'd2};
      words[2] = '{16'hFFFF, 9'd2, 1'b0, 9'd3};
      words[3] = '{16'h0001, 9'd3, 1'b1, 9'd0};
      words[4] = '{16'h8000, 9'd0, 1'b0, 9'd1};
      lanes[0] = '{16'hA5C3, 16'hA5C3, 16'h3C5A};
      lanes[1] = '{16'h1234, 16'h1234, 16'h4321};
      lanes[2] = '{16'hF000, 16'hF000, 16'h000F};

      #2 rst = 1'b1;
      #18;
      check("rst_ab", 32'(ab1), 0);
      check("rst_db", 32'(db1), 0);
      check("rst_wen", 32'(wen1), 0);
      check("rst_frame_done", 32'(fd1), 0);
      check("rst_short_err", 32'(se1), 0);
      check("rst_pix_cnt", 32'(pc1), 0);
      rst = 1'b0;
      @(posedge DCK);
      #1;

      // Back-to-back words through a 4-pixel frame with wrap.
      for (int w = 0; w < 5; w++) begin
         for (int i = 0; i < 16; i++) begin
            tick(1'b1, words[w].data[i], 1'b0);
            if (i == 0 && w > 0) check("wen_gap", 32'(wen1), 0);
         end
         check("word_wen", 32'(wen1), 1);
         check("word_db", 32'(db1), 32'(words[w].data));
         check("word_ab", 32'(ab1), 32'(words[w].ab));
         check("word_frame_done", 32'(fd1), 32'(words[w].fd));
         check("word_pix_cnt", 32'(pc1), 32'(words[w].pc));
      end
      tick(1'b0, 1'b0, 1'b0);
      check("idle_wen", 32'(wen1), 0);
      check("idle_short_err", 32'(se1), 0);

      // DEN drops after 7 bits.
      send_bits(16'h00FF, 7);
      tick(1'b0, 1'b0, 1'b0);
      check("short_err_pulse", 32'(se1), 1);
      check("short_wen", 32'(wen1), 0);
      check("short_pix_cnt", 32'(pc1), 1);
      tick(1'b0, 1'b0, 1'b0);
      check("short_err_clear", 32'(se1), 0);
      send_bits(16'h5A5A, 16);
      check("after_short_wen", 32'(wen1), 1);
      check("after_short_db", 32'(db1), 32'h5A5A);
      check("after_short_ab", 32'(ab1), 1);
      check("after_short_pix_cnt", 32'(pc1), 2);

      // clr on the edge that completes a word at pix_cnt=2.
      send_bits(16'hC0DE, 15);
      tick(1'b1, 1'b1, 1'b1);
      check("clr_last_wen", 32'(wen1), 1);
      check("clr_last_ab", 32'(ab1), 2);
      check("clr_last_db", 32'(db1), 32'hC0DE);
      check("clr_last_pix_cnt", 32'(pc1), 0);
      check("clr_last_frame_done", 32'(fd1), 0);
      tick(1'b0, 1'b0, 1'b0);

      // clr mid-word: partial discarded, no error, beat dropped.
      send_bits(16'hFFFF, 5);
      tick(1'b1, 1'b0, 1'b1);
      check("clr_mid_wen", 32'(wen1), 0);
      check("clr_mid_short_err", 32'(se1), 0);
      check("clr_mid_pix_cnt", 32'(pc1), 0);
      tick(1'b0, 1'b0, 1'b0);
      check("clr_mid_no_err", 32'(se1), 0);
      send_bits(16'h0F0F, 16);
      check("after_clr_ab", 32'(ab1), 0);
      check("after_clr_db", 32'(db1), 32'h0F0F);
      check("after_clr_pix_cnt", 32'(pc1), 1);

      // Asynchronous reset at bit 9.
      send_bits(16'hFFFF, 9);
      #2;
      den1 = 1'b0;
      rst  = 1'b1;
      #1;
      check("async_db", 32'(db1), 0);
      check("async_ab", 32'(ab1), 0);
      check("async_wen", 32'(wen1), 0);
      check("async_pix_cnt", 32'(pc1), 0);
      check("async_short_err", 32'(se1), 0);
      @(posedge DCK);
      #2 rst = 1'b0;
      @(posedge DCK);
      #1;
      check("post_rst_wen", 32'(wen1), 0);
      send_bits(16'h1357, 16);
      check("post_rst_word_wen", 32'(wen1), 1);
      check("post_rst_word_ab", 32'(ab1), 0);
      check("post_rst_word_db", 32'(db1), 32'h1357);
      check("post_rst_word_pix_cnt", 32'(pc1), 1);
      tick(1'b0, 1'b0, 1'b0);

      // 4-lane placement, both bit orders from the same beats.
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 4; k++) tick4(1'b1, lanes[v].beats[15-4*k -: 4]);
         check("lane_msb_wen", 32'(wenm), 1);
         check("lane_msb_db", 32'(dbm), 32'(lanes[v].exp_msb));
         check("lane_msb_ab", 32'(abm), 32'(v));
         check("lane_msb_pix_cnt", 32'(pcm), 32'(v + 1));
         check("lane_lsb_wen", 32'(wenl), 1);
         check("lane_lsb_db", 32'(dbl), 32'(lanes[v].exp_lsb));
         check("lane_lsb_ab", 32'(abl), 32'(v));
         check("lane_lsb_pix_cnt", 32'(pcl), 32'(v + 1));
      end
      tick4(1'b0, 4'h0);
      check("lane_idle_wen", 32'({wenm, wenl}), 0);
      check("lane_flags", 32'({fdm, sem, fdl, sel}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
